pal_registered: RTL and testbench

PAL_REGISTERED -- requirements
Module: pal_registered

---
 rtl/pal_registered_if.sv | 25 ++
 rtl/pal_registered.sv | 123 ++++++++++++
 tb/tb_pal_registered.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_registered_if.sv
// Serial configuration channel of the registered PAL: the loader is the master,
// and the PAL core is the slave that reports busy and done.
interface pal_cfg_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_busy;
  logic cfg_done;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_data,
    input  cfg_busy,
    input  cfg_done
  );

  modport slave (
    input  cfg_start,
    input  cfg_valid,
    input  cfg_data,
    output cfg_busy,
    output cfg_done
  );
endinterface

// File: rtl/pal_registered.sv
// Fuse-programmable PAL with per-output registered/combinational macrocells,
// configured by a bit-serial fuse stream shifted in through pal_cfg_if.
//
// state  | meaning
// UNCONF | no configuration since reset; y and q held at 0
// LOAD   | shifting fuse bits in; y and q held at 0
// ACTIVE | fuse array live; macrocells evaluate and capture
module pal_registered #(
  parameter int NUM_INPUTS       = 5,
  parameter int NUM_OUTPUTS      = 4,
  parameter int TERMS_PER_OUTPUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pal_cfg_if.slave               cfg,
  input  logic [NUM_INPUTS-1:0]  in_a,
  output logic [NUM_OUTPUTS-1:0] y
);

  localparam int NSIG      = NUM_INPUTS + NUM_OUTPUTS;
  localparam int L         = 2 * NSIG;
  localparam int NTERMS    = NUM_OUTPUTS * TERMS_PER_OUTPUT;
  localparam int MC_BASE   = NTERMS * L;
  localparam int FUSE_BITS = MC_BASE + 2 * NUM_OUTPUTS;
  localparam int CW        = $clog2(FUSE_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FUSE_BITS - 1);

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   shift_en;
  logic [FUSE_BITS-1:0]   fuse;
  logic [NUM_OUTPUTS-1:0] q;
  logic [NUM_OUTPUTS-1:0] sum;
  logic [NUM_OUTPUTS-1:0] mode;
  logic [NUM_OUTPUTS-1:0] inv;
  logic [NSIG-1:0]        sig;
  logic [L-1:0]           lit;
  logic [NTERMS-1:0]      term;

  // FSM state register and serial fuse shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNCONF;
      cnt   <= '0;
      fuse  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (shift_en)
        fuse <= {cfg.cfg_data, fuse[FUSE_BITS-1:1]};
    end
  end

  // Next-state logic; a start pulse overrides everything, including a valid bit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    if (cfg.cfg_start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (cfg.cfg_valid) begin
            shift_en = 1'b1;
            if (cnt == LAST_IDX) begin
              state_nxt = ACTIVE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        ACTIVE:  state_nxt = ACTIVE;
        default: state_nxt = state;
      endcase
    end
  end

  assign cfg.cfg_busy = (state == LOAD);
  assign cfg.cfg_done = (state == ACTIVE);

  // Feedback comes only from q, so the array is loop-free in every mode
  assign sig = {q, in_a};

  for (genvar k = 0; k < NSIG; k++) begin : g_lit
    assign lit[2*k]   = sig[k];
    assign lit[2*k+1] = ~sig[k];
  end

  // A term with no fuse blown is disabled rather than vacuously true
  for (genvar n = 0; n < NTERMS; n++) begin : g_term
    logic [L-1:0] tf;
    assign tf      = fuse[n*L +: L];
    assign term[n] = (|tf) & (&(~tf | lit));
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_mc
    assign sum[o]  = |term[o*TERMS_PER_OUTPUT +: TERMS_PER_OUTPUT];
    assign mode[o] = fuse[MC_BASE + 2*o];
    assign inv[o]  = fuse[MC_BASE + 2*o + 1];
  end

  // A start pulse in ACTIVE must already clear q at the edge that leaves ACTIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (state == ACTIVE && !cfg.cfg_start)
      q <= sum;
    else
      q <= '0;
  end

  assign y = (state == ACTIVE) ? (((mode & q) | (~mode & sum)) ^ inv) : '0;

endmodule

// File: tb/tb_pal_registered.sv
// Directed bench for pal_registered: serial fuse loads of hand-built images
// and checks of outputs, handshake flags, reset abort and reconfiguration.
module tb_pal_registered;
  localparam int FB = 296;

  logic       clk;
  logic       rst_n;
  logic [4:0] in_a;
  logic [3:0] y;
  int         tests;
  int         fails;

  pal_cfg_if cfg ();

  pal_registered dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg.slave),
    .in_a  (in_a),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic v, input logic d);
    cfg.cfg_start = 1'b1;
    cfg.cfg_valid = v;
    cfg.cfg_data  = d;
    step();
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 1'b0;
  endtask

  task automatic send_bits(input logic [FB-1:0] img, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cfg.cfg_valid = 1'b1;
      cfg.cfg_data  = img[i];
      step();
    end
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 1'b0;
  endtask

  task automatic load(input logic [FB-1:0] img);
    start_pulse(1'b0, 1'b0);
    send_bits(img, 0, FB-1);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    in_a          = 5'($urandom);
    cfg.cfg_start = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 1'b1;
    #3;
    tests++;
    if (y !== 4'b0000 || cfg.cfg_busy !== 1'b0 || cfg.cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: y=%b busy=%b done=%b expected 0000 0 0", y, cfg.cfg_busy, cfg.cfg_done);
    end
    step();
    step();
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 1'b0;
    rst_n = 1'b1;
    step();
    tests++;
    if (y !== 4'b0000 || cfg.cfg_busy !== 1'b0 || cfg.cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL unconf_idle: y=%b busy=%b done=%b expected 0000 0 0", y, cfg.cfg_busy, cfg.cfg_done);
    end
  endtask

  task automatic test_comb_and();
    logic [FB-1:0] img;
    img    = '0;
    img[0] = 1'b1;
    img[2] = 1'b1;
    load(img);
    tests++;
    if (cfg.cfg_done !== 1'b1 || cfg.cfg_busy !== 1'b0) begin
      fails++;
      $display("FAIL and_done: done=%b busy=%b expected 1 0", cfg.cfg_done, cfg.cfg_busy);
    end
    in_a = 5'b00011;
    #1;
    tests++;
    if (y !== 4'b0001) begin
      fails++;
      $display("FAIL and_11: y=%b expected 0001", y);
    end
    in_a = 5'b00001;
    #1;
    tests++;
    if (y !== 4'b0000) begin
      fails++;
      $display("FAIL and_01: y=%b expected 0000", y);
    end
    in_a = 5'b11110;
    #1;
    tests++;
    if (y !== 4'b0000) begin
      fails++;
      $display("FAIL and_1e: y=%b expected 0000", y);
    end
    in_a = 5'b11111;
    #1;
    tests++;
    if (y !== 4'b0001) begin
      fails++;
      $display("FAIL and_1f: y=%b expected 0001", y);
    end
  endtask

  task automatic test_toggle();
    logic [FB-1:0] img;
    logic [3:0]    exp_seq;
    img      = '0;
    img[85]  = 1'b1;
    img[290] = 1'b1;
    in_a     = 5'b00000;
    exp_seq  = 4'b1010;
    load(img);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (y[1] !== exp_seq[i]) begin
        fails++;
        $display("FAIL toggle_%0d: y1=%b expected %b", i, y[1], exp_seq[i]);
      end
      step();
    end
  endtask

  task automatic test_invert();
    logic [FB-1:0] img;
    img      = '0;
    img[293] = 1'b1;
    start_pulse(1'b0, 1'b0);
    tests++;
    if (cfg.cfg_busy !== 1'b1 || cfg.cfg_done !== 1'b0 || y !== 4'b0000) begin
      fails++;
      $display("FAIL inv_load: busy=%b done=%b y=%b expected 1 0 0000", cfg.cfg_busy, cfg.cfg_done, y);
    end
    send_bits(img, 0, FB-2);
    tests++;
    if (cfg.cfg_done !== 1'b0 || y !== 4'b0000) begin
      fails++;
      $display("FAIL inv_almost: done=%b y=%b expected 0 0000", cfg.cfg_done, y);
    end
    send_bits(img, FB-1, FB-1);
    tests++;
    if (cfg.cfg_done !== 1'b1 || y !== 4'b0100) begin
      fails++;
      $display("FAIL inv_active: done=%b y=%b expected 1 0100", cfg.cfg_done, y);
    end
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 1'b1;
    step();
    step();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 1'b0;
    tests++;
    if (cfg.cfg_done !== 1'b1 || y !== 4'b0100) begin
      fails++;
      $display("FAIL valid_ignored: done=%b y=%b expected 1 0100", cfg.cfg_done, y);
    end
  endtask

  task automatic test_abort();
    logic [FB-1:0] img;
    img      = '0;
    img[293] = 1'b1;
    start_pulse(1'b0, 1'b0);
    send_bits({FB{1'b1}}, 0, 99);
    rst_n = 1'b0;
    #2;
    tests++;
    if (cfg.cfg_busy !== 1'b0 || cfg.cfg_done !== 1'b0 || y !== 4'b0000) begin
      fails++;
      $display("FAIL abort: busy=%b done=%b y=%b expected 0 0 0000", cfg.cfg_busy, cfg.cfg_done, y);
    end
    rst_n = 1'b1;
    step();
    load(img);
    tests++;
    if (cfg.cfg_done !== 1'b1 || y !== 4'b0100) begin
      fails++;
      $display("FAIL abort_reload: done=%b y=%b expected 1 0100", cfg.cfg_done, y);
    end
  endtask

  task automatic test_reconfig();
    logic [FB-1:0] img;
    img    = '0;
    img[0] = 1'b1;
    img[2] = 1'b1;
    in_a   = 5'b00011;
    start_pulse(1'b1, 1'b1);
    tests++;
    if (cfg.cfg_done !== 1'b0 || cfg.cfg_busy !== 1'b1 || y !== 4'b0000) begin
      fails++;
      $display("FAIL reconf_start: done=%b busy=%b y=%b expected 0 1 0000", cfg.cfg_done, cfg.cfg_busy, y);
    end
    send_bits(img, 0, FB-2);
    tests++;
    if (cfg.cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL reconf_295: done=%b expected 0", cfg.cfg_done);
    end
    send_bits(img, FB-1, FB-1);
    tests++;
    if (cfg.cfg_done !== 1'b1 || y !== 4'b0001) begin
      fails++;
      $display("FAIL reconf_296: done=%b y=%b expected 1 0001", cfg.cfg_done, y);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    in_a          = '0;
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 1'b0;
    test_reset();
    test_comb_and();
    test_toggle();
    test_invert();
    test_abort();
    test_reconfig();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
